// File: rtl/first_nios2_system_sysid_pkg.sv
// Shared definitions for the sysid checker and the sysid control slave:
// FSM states, word offsets and default expected contents.
package first_nios2_system_sysid_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        DONE  = 2'd3
    } sysid_state_e;

    localparam logic        SYSID_ID_WORD              = 1'b0;
    localparam logic        SYSID_TS_WORD              = 1'b1;
    localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd0;
    localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1453660413;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES     = 255;
    localparam int          WAIT_CNT_WIDTH             = 16;

    function automatic logic is_read_state(input sysid_state_e s);
        return (s == RD_ID) || (s == RD_TS);
    endfunction

endpackage

// File: rtl/first_nios2_system_wait_timer.sv
// Stall counter for one Avalon read: cleared on entry to a read state,
// counts waitrequest-high cycles and flags when the limit is reached.
module first_nios2_system_wait_timer
    import first_nios2_system_sysid_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      clear_i,
    input  logic                      en_i,
    input  logic [WAIT_CNT_WIDTH-1:0] limit_i,
    output logic                      expired_o
);

    logic [WAIT_CNT_WIDTH-1:0] count_q, count_d;

    // Holding at the limit keeps the count from wrapping if the owner lingers.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != limit_i)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == limit_i);

endmodule

// File: rtl/first_nios2_system_sysid_checker.sv
// Avalon-MM master that reads the sysid ID and timestamp words, compares them
// against build-time values and reports pass/fail/timeout to boot logic.
module first_nios2_system_sysid_checker
    import first_nios2_system_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
    parameter int unsigned TIMEOUT_CYCLES     = DEFAULT_TIMEOUT_CYCLES,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        address,
    output logic        read,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_match,
    output logic        ts_match,
    output logic        timeout,
    output logic [31:0] captured_id,
    output logic [31:0] captured_timestamp
);

    localparam logic [WAIT_CNT_WIDTH-1:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[WAIT_CNT_WIDTH-1:0];

    sysid_state_e state_q, state_d;
    logic         auto_pending_q, auto_pending_d;
    logic         id_match_q, id_match_d;
    logic         ts_match_q, ts_match_d;
    logic         timeout_q, timeout_d;
    logic [31:0]  captured_id_q, captured_id_d;
    logic [31:0]  captured_ts_q, captured_ts_d;
    logic         clear_results;
    logic         accept;
    logic         stalled;
    logic         expired;
    logic         timer_clear;

    // read/address come straight from state, so they cannot move while stalled.
    assign read    = is_read_state(state_q);
    assign address = (state_q == RD_TS) ? SYSID_TS_WORD : SYSID_ID_WORD;
    assign accept  = read && !waitrequest;
    assign stalled = read && waitrequest;

    always_comb begin
        state_d        = state_q;
        auto_pending_d = auto_pending_q;
        id_match_d     = id_match_q;
        ts_match_d     = ts_match_q;
        timeout_d      = timeout_q;
        captured_id_d  = captured_id_q;
        captured_ts_d  = captured_ts_q;
        clear_results  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start || auto_pending_q) begin
                    auto_pending_d = 1'b0;
                    clear_results  = 1'b1;
                    state_d        = RD_ID;
                end
            end
            RD_ID: begin
                if (accept) begin
                    captured_id_d = readdata;
                    id_match_d    = (readdata == EXPECTED_ID);
                    state_d       = RD_TS;
                end else if (stalled && expired) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            RD_TS: begin
                if (accept) begin
                    captured_ts_d = readdata;
                    ts_match_d    = (readdata == EXPECTED_TIMESTAMP);
                    state_d       = DONE;
                end else if (stalled && expired) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    clear_results = 1'b1;
                    state_d       = RD_ID;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear_results) begin
            id_match_d    = 1'b0;
            ts_match_d    = 1'b0;
            timeout_d     = 1'b0;
            captured_id_d = '0;
            captured_ts_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            auto_pending_q <= AUTO_START;
            id_match_q     <= 1'b0;
            ts_match_q     <= 1'b0;
            timeout_q      <= 1'b0;
            captured_id_q  <= '0;
            captured_ts_q  <= '0;
        end else begin
            state_q        <= state_d;
            auto_pending_q <= auto_pending_d;
            id_match_q     <= id_match_d;
            ts_match_q     <= ts_match_d;
            timeout_q      <= timeout_d;
            captured_id_q  <= captured_id_d;
            captured_ts_q  <= captured_ts_d;
        end
    end

    // Each read state starts its stall budget from zero.
    assign timer_clear = is_read_state(state_d) && (state_d != state_q);

    first_nios2_system_wait_timer u_wait_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear_i   (timer_clear),
        .en_i      (stalled),
        .limit_i   (TIMEOUT_LIMIT),
        .expired_o (expired)
    );

    assign busy               = read;
    assign done               = (state_q == DONE);
    assign pass               = done && id_match_q && ts_match_q && !timeout_q;
    assign id_match           = id_match_q;
    assign ts_match           = ts_match_q;
    assign timeout            = timeout_q;
    assign captured_id        = captured_id_q;
    assign captured_timestamp = captured_ts_q;

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// Bench for the sysid checker: one auto-start instance (short timeout) and one
// manual-start instance, each checked cycle by cycle against a schedule model.
module tb_first_nios2_system_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1453660413;
    localparam int          T_A    = 8;
    localparam int          T_B    = 255;

    typedef struct packed {
        logic        read;
        logic        address;
        logic        busy;
        logic        done;
        logic        pass;
        logic        id_match;
        logic        ts_match;
        logic        timeout;
        logic [31:0] cap_id;
        logic [31:0] cap_ts;
    } obs_t;

    // clock / reset
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [1:0]  reset_n_w;
    logic [1:0]  start_w;
    logic [1:0]  waitreq_w;
    logic [31:0] id_val;
    logic [31:0] ts_val;

    logic        read_a, address_a, busy_a, done_a, pass_a, id_match_a, ts_match_a, timeout_a;
    logic [31:0] readdata_a, cap_id_a, cap_ts_a;
    logic        read_b, address_b, busy_b, done_b, pass_b, id_match_b, ts_match_b, timeout_b;
    logic [31:0] readdata_b, cap_id_b, cap_ts_b;

    // Sysid slave model: word 0 = ID, word 1 = timestamp.
    assign readdata_a = address_a ? ts_val : id_val;
    assign readdata_b = address_b ? ts_val : id_val;

    first_nios2_system_sysid_checker #(
        .EXPECTED_ID        (EXP_ID),
        .EXPECTED_TIMESTAMP (EXP_TS),
        .TIMEOUT_CYCLES     (T_A),
        .AUTO_START         (1'b1)
    ) u_dut_a (
        .clock              (clock),
        .reset_n            (reset_n_w[0]),
        .start              (start_w[0]),
        .address            (address_a),
        .read               (read_a),
        .waitrequest        (waitreq_w[0]),
        .readdata           (readdata_a),
        .busy               (busy_a),
        .done               (done_a),
        .pass               (pass_a),
        .id_match           (id_match_a),
        .ts_match           (ts_match_a),
        .timeout            (timeout_a),
        .captured_id        (cap_id_a),
        .captured_timestamp (cap_ts_a)
    );

    first_nios2_system_sysid_checker #(
        .EXPECTED_ID        (EXP_ID),
        .EXPECTED_TIMESTAMP (EXP_TS),
        .TIMEOUT_CYCLES     (T_B),
        .AUTO_START         (1'b0)
    ) u_dut_b (
        .clock              (clock),
        .reset_n            (reset_n_w[1]),
        .start              (start_w[1]),
        .address            (address_b),
        .read               (read_b),
        .waitrequest        (waitreq_w[1]),
        .readdata           (readdata_b),
        .busy               (busy_b),
        .done               (done_b),
        .pass               (pass_b),
        .id_match           (id_match_b),
        .ts_match           (ts_match_b),
        .timeout            (timeout_b),
        .captured_id        (cap_id_b),
        .captured_timestamp (cap_ts_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic obs_t get_obs(input int s);
        obs_t o;
        if (s == 0) begin
            o = '{read_a, address_a, busy_a, done_a, pass_a, id_match_a, ts_match_a, timeout_a,
                  cap_id_a, cap_ts_a};
        end else begin
            o = '{read_b, address_b, busy_b, done_b, pass_b, id_match_b, ts_match_b, timeout_b,
                  cap_id_b, cap_ts_b};
        end
        return o;
    endfunction

    task automatic check_all(input int s, input string tag, input obs_t e);
        obs_t o;
        o = get_obs(s);
        check({tag, ".read"},     32'(o.read),     32'(e.read));
        check({tag, ".address"},  32'(o.address),  32'(e.address));
        check({tag, ".busy"},     32'(o.busy),     32'(e.busy));
        check({tag, ".done"},     32'(o.done),     32'(e.done));
        check({tag, ".pass"},     32'(o.pass),     32'(e.pass));
        check({tag, ".id_match"}, 32'(o.id_match), 32'(e.id_match));
        check({tag, ".ts_match"}, 32'(o.ts_match), 32'(e.ts_match));
        check({tag, ".timeout"},  32'(o.timeout),  32'(e.timeout));
        check({tag, ".cap_id"},   o.cap_id,        e.cap_id);
        check({tag, ".cap_ts"},   o.cap_ts,        e.cap_ts);
    endtask

    // Driver + reference model for one check. Called at a negedge; the next
    // posedge (edge 1) must move the DUT into RD_ID. Slave stalls s0/s1 cycles
    // on word 0/1; a read whose stall exceeds the limit is abandoned after limit+1
    // cycles. extra_start pulses start during interval extra_start (0 = never).
    task automatic run(input int s, input int s0, input int s1, input logic [31:0] idv,
                       input logic [31:0] tsv, input bit use_start, input int extra_start,
                       input string tag);
        int   t, n0, n1, last;
        bit   to0, to1;
        obs_t e;
        t    = (s == 0) ? T_A : T_B;
        to0  = (s0 > t);
        n0   = to0 ? t + 1 : s0 + 1;
        to1  = !to0 && (s1 > t);
        n1   = to0 ? 0 : (to1 ? t + 1 : s1 + 1);
        last = n0 + n1 + 1;
        id_val       = idv;
        ts_val       = tsv;
        start_w[s]   = use_start;
        waitreq_w[s] = 1'b0;
        for (int j = 1; j <= last + 1; j++) begin
            @(posedge clock);
            @(negedge clock);
            start_w[s] = (j == extra_start);
            e.read     = (j < last);
            e.busy     = e.read;
            e.address  = (j > n0) && (j < last);
            e.done     = (j >= last);
            e.id_match = !to0 && (j > n0) && (idv == EXP_ID);
            e.cap_id   = (!to0 && (j > n0)) ? idv : 32'd0;
            e.ts_match = !to0 && !to1 && (j >= last) && (tsv == EXP_TS);
            e.cap_ts   = (!to0 && !to1 && (j >= last)) ? tsv : 32'd0;
            e.timeout  = (j >= last) && (to0 || to1);
            e.pass     = e.done && e.id_match && e.ts_match && !e.timeout;
            check_all(s, $sformatf("%s.c%0d", tag, j), e);
            if (j <= n0) begin
                waitreq_w[s] = ((j - 1) < s0);
            end else if (j < last) begin
                waitreq_w[s] = ((j - 1 - n0) < s1);
            end else begin
                waitreq_w[s] = 1'b0;
            end
        end
        start_w[s]   = 1'b0;
        waitreq_w[s] = 1'b0;
    endtask

    initial begin
        obs_t        zero_obs;
        int          r0, r1;
        logic [31:0] ridv, rtsv;
        zero_obs  = '0;
        reset_n_w = 2'b00;
        start_w   = 2'b00;
        waitreq_w = 2'b00;
        id_val    = 32'd0;
        ts_val    = 32'd0;
        repeat (3) @(negedge clock);
        check_all(0, "reset_a", zero_obs);
        check_all(1, "reset_b", zero_obs);

        // Auto-start instance: power-up check, then restarts from DONE.
        reset_n_w[0] = 1'b1;
        run(0, 0, 0, EXP_ID, EXP_TS, 1'b0, 0, "auto_zero_wait");
        run(0, 0, 0, EXP_ID, EXP_TS - 32'd1, 1'b1, 0, "ts_mismatch");
        run(0, 4, 2, EXP_ID, EXP_TS, 1'b1, 0, "stall_4_2");
        run(0, 0, 1000, EXP_ID, EXP_TS, 1'b1, 0, "timeout_ts");
        run(0, 1000, 0, EXP_ID, EXP_TS, 1'b1, 0, "timeout_id");
        run(0, T_A, T_A, EXP_ID, EXP_TS, 1'b1, 0, "stall_at_limit");
        run(0, T_A + 1, 0, EXP_ID, EXP_TS, 1'b1, 0, "stall_over_limit");
        run(0, 0, 0, 32'hDEAD_BEEF, EXP_TS, 1'b1, 0, "id_mismatch");
        for (int k = 0; k < 6; k++) begin
            r0   = $urandom_range(0, T_A + 2);
            r1   = $urandom_range(0, T_A + 2);
            ridv = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom();
            rtsv = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom();
            run(0, r0, r1, ridv, rtsv, 1'b1, 0, $sformatf("rand%0d", k));
        end

        // Reset while stalled in RD_ID, then the auto check must rerun.
        start_w[0]   = 1'b1;
        waitreq_w[0] = 1'b1;
        repeat (3) begin
            @(posedge clock);
            @(negedge clock);
            start_w[0] = 1'b0;
        end
        check("midrst.read_before", 32'(read_a), 32'd1);
        reset_n_w[0] = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_all(0, "midrst", zero_obs);
        reset_n_w[0] = 1'b1;
        waitreq_w[0] = 1'b0;
        run(0, 0, 0, EXP_ID, EXP_TS, 1'b0, 0, "auto_after_reset");

        // Manual-start instance: nothing happens until start.
        reset_n_w[1] = 1'b1;
        repeat (5) begin
            @(posedge clock);
            @(negedge clock);
            check_all(1, "man_idle", zero_obs);
        end
        run(1, 3, 0, 32'h0000_1234, EXP_TS, 1'b1, 2, "man_first");
        run(1, 0, 2, EXP_ID, EXP_TS, 1'b1, 1, "man_rerun");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/first_nios2_system_sysid_checker.md
# first_nios2_system_sysid_checker

Avalon-MM master that reads the two-word system ID peripheral (word 0 = system ID, word 1 = build timestamp) after reset or on request. It compares both words against build-time expected values and reports pass/fail and timeout status to boot/diagnostic logic. It sits on the same system interconnect as the sysid slave, on the master side of the sysid control slave.

## Interface
Parameters:
- EXPECTED_ID, 32'd0, value required at word 0
- EXPECTED_TIMESTAMP, 32'd1453660413, value required at word 1
- TIMEOUT_CYCLES, 255, maximum consecutive waitrequest-high cycles per read (1..65535)
- AUTO_START, 1, launch one check automatically after reset

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  reset, synchronous, active-low
- start  in  1  single-cycle pulse; begins a check when idle or done
- address  out  1  word address to sysid slave
- read  out  1  Avalon read strobe
- waitrequest  in  1  slave stall; tie 0 for zero-wait slave
- readdata  in  32  slave read data, valid when read && !waitrequest
- busy  out  1  check in progress
- done  out  1  check finished (sticky until next start)
- pass  out  1  id_match && ts_match && !timeout, valid when done
- id_match  out  1  word 0 equalled EXPECTED_ID
- ts_match  out  1  word 1 equalled EXPECTED_TIMESTAMP
- timeout  out  1  a read exceeded TIMEOUT_CYCLES
- captured_id  out  32  word 0 as read
- captured_timestamp  out  32  word 1 as read

## Operation
- States: IDLE, RD_ID, RD_TS, DONE. All outputs registered or decoded from state only.
- IDLE: read=0, address=0, busy=0. Go to RD_ID if start=1 or auto_pending=1; auto_pending is cleared on that transition.
- RD_ID: read=1, address=0, busy=1. On read && !waitrequest: captured_id<=readdata, id_match<=(readdata==EXPECTED_ID), go to RD_TS.
- RD_TS: read=1, address=1, busy=1. On accept: captured_timestamp<=readdata, ts_match<=(readdata==EXPECTED_TIMESTAMP), go to DONE.
- DONE: read=0, busy=0, done=1, pass per definition. A start pulse clears done, id_match, ts_match, timeout, pass and both captured words to 0, then goes to RD_ID.
- Timeout: the wait counter (16 bit) clears on entry to each read state and increments on each cycle with waitrequest=1. When the counter equals TIMEOUT_CYCLES with waitrequest still 1, the check abandons: timeout<=1, the unread word's match flag stays 0, and the state goes to DONE.
- start in RD_ID/RD_TS is ignored, with no restart and no queueing. start coinciding with an accept is ignored.
- read and address are held stable while waitrequest=1, per Avalon rules.

## Timing
- Reset values: state=IDLE, auto_pending=AUTO_START, read=0, address=0, busy=0, done=0, pass=0, id_match=0, ts_match=0, timeout=0, captured_id=0, captured_timestamp=0, counter=0.
- Reset is sampled on a clock edge. Asserting it mid-read drops read on that same edge, and no partial result survives.
- Zero-wait slave: edge 1 after reset release goes IDLE→RD_ID, edge 2 accepts word 0, edge 3 accepts word 1 and asserts done. done is high 3 cycles after the first cycle with reset_n=1.
- Each waitrequest-high cycle adds one cycle to the corresponding read.
- Timeout: done rises TIMEOUT_CYCLES+1 edges after entry to the stalled read state.
- Restart from DONE: start sampled on edge N puts read=1, address=0 after edge N, and done rises at edge N+2 with zero wait.

## Structure
- Shared package first_nios2_system_sysid_pkg: state enum (IDLE, RD_ID, RD_TS, DONE), word offsets SYSID_ID_WORD=0 and SYSID_TS_WORD=1, and default expected-value constants. The sysid slave reuses the same constants.
- Sub-module first_nios2_system_wait_timer: loadable 16-bit stall counter with clear, enable and expired outputs. Everything else stays in the top.

## Test plan
- Zero-wait slave, AUTO_START=1, slave returns 0 and 1453660413 → done at cycle 3, pass=1, id_match=1, ts_match=1, timeout=0.
- Slave returns 0 and 1453660412 → done=1, id_match=1, ts_match=0, pass=0, captured_timestamp=1453660412.
- waitrequest high for 4 cycles on word 0 and 2 on word 1 → read/address stable while stalled, done at cycle 9, pass=1.
- TIMEOUT_CYCLES=8, waitrequest stuck high in RD_TS → done at 9 edges after RD_TS entry, timeout=1, ts_match=0, pass=0, read=0 afterwards.
- AUTO_START=0: no read until start; start pulsed again during RD_ID is ignored; start in DONE clears all flags and reruns → second pass=1.
- reset_n low for one cycle while stalled in RD_ID → next cycle read=0, all outputs at reset values, and the auto check reruns after release.
